if_fetch_stage: RTL and testbench
=================================

Name: if_fetch_stage

Overview:
Instruction-fetch stage directly upstream of the decode stage. Holds the PC, issues single-outstanding requests to instruction memory over a req/gnt/rvalid handshake, and buffers returned words with their PC in a small FIFO. Presents one instruction per cycle to decode, honours decode back-pressure (stall_in), and flushes on a redirect from branch/jump resolution.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
FIFO_DEPTH, 2, instruction buffer entries (power of two, >=2)
NOP_INSTR, 32'h0000_0013, value driven on instr_out when no valid instruction (ADDI x0,x0,0)

Ports:
clk  in  1  clock
rst_n  in  1  reset, asynchronous, active-low
stall_in  in  1  decode stage cannot accept; hold head of buffer
redirect_valid  in  1  branch/jump taken; flush and restart fetch
redirect_pc  in  32  new fetch address
imem_req  out  1  fetch request valid
imem_addr  out  32  fetch address, word-aligned
imem_gnt  in  1  memory accepts request this cycle
imem_rvalid  in  1  read data valid (at least 1 cycle after gnt, in order)
imem_rdata  in  32  instruction word
instr_valid_out  out  1  instr_out/pc_out hold a real instruction
instr_out  out  32  instruction to decode
pc_out  out  32  PC of instr_out

Behaviour:
- Reset (async, rst_n=0): pc=RESET_PC, FIFO empty, state IDLE, drop flag 0; imem_req=0, imem_addr=RESET_PC, instr_valid_out=0, instr_out=NOP_INSTR, pc_out=0.
- FSM states: IDLE, REQ, WAIT.
  - IDLE -> REQ when free space exists (occupancy < FIFO_DEPTH).
  - REQ: imem_req=1, imem_addr=pc. On gnt: latch req_pc=pc, pc<=pc+4 (wraps mod 2^32), -> WAIT.
  - WAIT: imem_req=0. On rvalid: push {req_pc, rdata} unless drop flag set; clear drop; -> REQ if space after this cycle's push/pop, else IDLE.
- Space is reserved: a request is issued only if occupancy + outstanding < FIFO_DEPTH, so a push never overflows.
- Output: instr_valid_out = FIFO non-empty; instr_out/pc_out = head entry; when empty, instr_out=NOP_INSTR and pc_out holds its last value.
- Pop when instr_valid_out && !stall_in. Push and pop in the same cycle are allowed at any occupancy. Occupancy is unchanged in that case.
- Latency: gnt at cycle N, rvalid at N+1 -> instr_valid_out high at N+2 if buffer was empty (registered FIFO write).
- Redirect (highest priority, one cycle):
  - FIFO cleared, same cycle pop suppressed, and push suppressed.
  - pc <= {redirect_pc[31:2],2'b00}; misaligned low bits ignored.
  - If in WAIT with no rvalid this cycle, or in REQ with gnt this cycle, set drop so that response is discarded; FSM goes/stays WAIT.
  - Otherwise -> REQ next cycle.
  - instr_valid_out=0 the cycle after redirect.
- Redirect with rvalid same cycle: response discarded, no drop flag needed.
- stall_in during redirect: redirect still wins.
- imem_req, once asserted, holds with a stable imem_addr until gnt or redirect. Redirect may withdraw a pending ungranted request.
- Reset mid-transaction: any outstanding response arriving after reset release is discarded only if drop logic allows. Memory is required to be reset together; no recovery is specified.

Optional Feature:
IF_PERF_CNT_EN: when defined, adds outputs perf_fetched (32-bit, count of words pushed to the FIFO) and perf_flushed (32-bit, count of FIFO entries plus dropped responses discarded by redirects). Both reset to 0 and wrap. When not defined, the ports and logic are absent and behaviour is otherwise identical.

Test Plan:
- Reset, gnt=1, rvalid one cycle after gnt, stall_in=0, memory returns addr-indexed words -> pc_out sequence 0,4,8,C… with matching instr_out; first instr_valid_out 2 cycles after first gnt.
- stall_in=1 for 5 cycles with memory streaming -> FIFO fills to 2, imem_req drops, instr_out/pc_out stable. Release -> no word lost or duplicated.
- Gnt withheld 3 cycles -> imem_req held, imem_addr stable; instr_valid_out=0 with instr_out=32'h00000013.
- Redirect to 32'h0000_0103 while in WAIT -> next imem_addr=32'h0000_0100; the in-flight response is dropped; first valid pc_out=0x100.
- Redirect in same cycle as rvalid, and separately in same cycle as gnt -> neither response reaches instr_out.
- rst_n asserted mid-WAIT -> outputs take reset values asynchronously; fetch restarts at RESET_PC. With IF_PERF_CNT_EN, counters read 0 after reset and match pushed/flushed counts.

Source files
------------

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC, single-outstanding imem handshake, FIFO of {pc, instr} feeding decode.
// Optional build macro IF_PERF_CNT_EN adds perf_fetched / perf_flushed counters.
module if_fetch_stage #(
   parameter logic [31:0] RESET_PC   = 32'h0000_0000,
   parameter int          FIFO_DEPTH = 2,
   parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        stall_in,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        imem_req,
   output logic [31:0] imem_addr,
   input  logic        imem_gnt,
   input  logic        imem_rvalid,
   input  logic [31:0] imem_rdata,
   output logic        instr_valid_out,
   output logic [31:0] instr_out,
   output logic [31:0] pc_out
`ifdef IF_PERF_CNT_EN
   ,
   output logic [31:0] perf_fetched,
   output logic [31:0] perf_flushed
`endif
);

   localparam int               PTR_W   = $clog2(FIFO_DEPTH);
   localparam int               CNT_W   = PTR_W + 1;
   localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(FIFO_DEPTH);

   localparam logic [1:0] S_IDLE = 2'd0;
   localparam logic [1:0] S_REQ  = 2'd1;
   localparam logic [1:0] S_WAIT = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [31:0]      pc_q, pc_d;
   logic [31:0]      req_pc_q;
   logic             drop_q, drop_d;
   logic [31:0]      fifo_instr [FIFO_DEPTH];
   logic [31:0]      fifo_pc    [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0] count_q, count_d;
   logic [31:0]      last_pc_q;
   logic             push, pop;

   assign instr_valid_out = (count_q != '0);
   assign instr_out       = instr_valid_out ? fifo_instr[rd_ptr_q] : NOP_INSTR;
   assign pc_out          = instr_valid_out ? fifo_pc[rd_ptr_q] : last_pc_q;
   assign imem_req        = (state_q == S_REQ);
   assign imem_addr       = pc_q;

   // A redirect squashes both ends of the buffer in the cycle it is seen.
   assign pop  = instr_valid_out && !stall_in && !redirect_valid;
   assign push = (state_q == S_WAIT) && imem_rvalid && !drop_q && !redirect_valid;

   always_comb begin
      count_d = count_q + CNT_W'(push) - CNT_W'(pop);
      if (redirect_valid) count_d = '0;
   end

   // Fetch control: a request is only raised when the returned word is guaranteed a FIFO slot.
   always_comb begin
      state_d = state_q;
      pc_d    = pc_q;
      drop_d  = drop_q;
      if (redirect_valid) begin
         pc_d = {redirect_pc[31:2], 2'b00};
         if ((state_q == S_WAIT && !imem_rvalid) || (state_q == S_REQ && imem_gnt)) begin
            drop_d  = 1'b1;
            state_d = S_WAIT;
         end else begin
            drop_d  = 1'b0;
            state_d = S_REQ;
         end
      end else begin
         case (state_q)
            S_IDLE: begin
               if (count_q < DEPTH_C) state_d = S_REQ;
            end
            S_REQ: begin
               if (imem_gnt) begin
                  pc_d    = pc_q + 32'd4;
                  state_d = S_WAIT;
               end
            end
            S_WAIT: begin
               if (imem_rvalid) begin
                  drop_d  = 1'b0;
                  state_d = (count_d < DEPTH_C) ? S_REQ : S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         pc_q      <= {RESET_PC[31:2], 2'b00};
         drop_q    <= 1'b0;
         count_q   <= '0;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         last_pc_q <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         drop_q    <= drop_d;
         count_q   <= count_d;
         last_pc_q <= pc_out;
         if (redirect_valid) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
         end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
         end
      end
   end

   // Buffer storage: the PC travels with its word so decode never reconstructs it.
   always_ff @(posedge clk) begin
      if (state_q == S_REQ && imem_gnt) req_pc_q <= pc_q;
      if (push) begin
         fifo_instr[wr_ptr_q] <= imem_rdata;
         fifo_pc[wr_ptr_q]    <= req_pc_q;
      end
   end

`ifdef IF_PERF_CNT_EN
   logic resp_discard;
   assign resp_discard = (state_q == S_WAIT) && imem_rvalid && (drop_q || redirect_valid);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         perf_fetched <= '0;
         perf_flushed <= '0;
      end else begin
         if (push) perf_fetched <= perf_fetched + 32'd1;
         perf_flushed <= perf_flushed + (redirect_valid ? 32'(count_q) : 32'd0)
                         + 32'(resp_discard);
      end
   end
`endif

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: responder memory, stream-level reference model, directed scenarios.
module tb_if_fetch_stage;

   localparam logic [31:0] RESET_PC  = 32'h0000_0000;
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        stall_in;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        imem_req;
   logic [31:0] imem_addr;
   logic        imem_gnt;
   logic        imem_rvalid;
   logic [31:0] imem_rdata;
   logic        instr_valid_out;
   logic [31:0] instr_out;
   logic [31:0] pc_out;

   int vectors     = 0;
   int miscompares = 0;

   bit          gnt_en   = 1'b1;
   int          rv_delay = 0;
   logic [31:0] pcs [8];
   logic [31:0] ins [8];
   int          got;

   if_fetch_stage #(
      .RESET_PC  (RESET_PC),
      .FIFO_DEPTH(2),
      .NOP_INSTR (NOP_INSTR)
   ) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .stall_in       (stall_in),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .imem_req       (imem_req),
      .imem_addr      (imem_addr),
      .imem_gnt       (imem_gnt),
      .imem_rvalid    (imem_rvalid),
      .imem_rdata     (imem_rdata),
      .instr_valid_out(instr_valid_out),
      .instr_out      (instr_out),
      .pc_out         (pc_out)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return a ^ 32'h5A5A_0000;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   // Memory: grants when enabled, answers in order rv_delay+1 cycles after the grant.
   initial begin
      bit          fire, pending;
      logic [31:0] fire_addr, pend_addr;
      int          wait_left;
      fire = 0; pending = 0; wait_left = 0; fire_addr = '0; pend_addr = '0;
      imem_gnt = 0; imem_rvalid = 0; imem_rdata = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            fire = 0; pending = 0; imem_gnt = 0; imem_rvalid = 0;
         end else begin
            if (fire) begin
               pending = 1; pend_addr = fire_addr; wait_left = rv_delay; fire = 0;
            end
            imem_rvalid = 0;
            if (pending) begin
               if (wait_left == 0) begin
                  imem_rvalid = 1; imem_rdata = mem_word(pend_addr); pending = 0;
               end else wait_left--;
            end
            imem_gnt = gnt_en && imem_req;
            if (imem_gnt) begin
               fire = 1; fire_addr = imem_addr;
            end
         end
      end
   end

   // Reference model: decode sees consecutive PCs from the last restart point, one per pop.
   initial begin
      logic [31:0] exp_pc, last_pc, prev_rpc, fetch_pc;
      bit          prev_redir, prev_pop, prev_hold;
      exp_pc = RESET_PC; last_pc = '0; prev_rpc = '0; fetch_pc = RESET_PC;
      prev_redir = 0; prev_pop = 0; prev_hold = 0;
      forever begin
         @(negedge clk);
         #2;
         if (!rst_n) begin
            exp_pc = RESET_PC; last_pc = '0; fetch_pc = RESET_PC;
            prev_redir = 0; prev_pop = 0; prev_hold = 0;
         end else begin
            if (prev_redir) exp_pc = prev_rpc;
            else if (prev_pop) exp_pc = exp_pc + 32'd4;
            if (prev_redir) check("valid_after_redirect", instr_valid_out, 1'b0);
            if (prev_hold) check("req_held_until_gnt", imem_req, 1'b1);
            if (imem_req) check("imem_addr_stream", imem_addr, fetch_pc);
            if (instr_valid_out) begin
               check("pc_out_stream", pc_out, exp_pc);
               check("instr_out_stream", instr_out, mem_word(exp_pc));
               last_pc = exp_pc;
            end else begin
               check("instr_out_nop", instr_out, NOP_INSTR);
               check("pc_out_hold", pc_out, last_pc);
            end
            prev_redir = redirect_valid;
            prev_rpc   = {redirect_pc[31:2], 2'b00};
            prev_pop   = instr_valid_out && !stall_in;
            prev_hold  = imem_req && !imem_gnt && !redirect_valid;
            if (redirect_valid) fetch_pc = {redirect_pc[31:2], 2'b00};
            else if (imem_req && imem_gnt) fetch_pc = fetch_pc + 32'd4;
         end
      end
   end

   task automatic collect(input int n);
      got = 0;
      for (int i = 0; i < 80 && got < n; i++) begin
         if (instr_valid_out && !stall_in && !redirect_valid) begin
            pcs[got] = pc_out; ins[got] = instr_out; got++;
         end
         tick();
      end
      check("pop_count", 32'(got), 32'(n));
   endtask

   task automatic wait_gnt();
      int i = 0;
      while (!(imem_req && imem_gnt) && i < 40) begin
         tick(); i++;
      end
      check("gnt_seen", 32'(imem_req && imem_gnt), 32'd1);
   endtask

   task automatic wait_req();
      int i = 0;
      while (!imem_req && i < 40) begin
         tick(); i++;
      end
      check("req_seen", 32'(imem_req), 32'd1);
   endtask

   initial begin
      int t_gnt, t_val;
      rst_n = 0; stall_in = 0; redirect_valid = 0; redirect_pc = '0;
      repeat (2) tick();
      check("rst_imem_req", imem_req, 1'b0);
      check("rst_imem_addr", imem_addr, RESET_PC);
      check("rst_valid", instr_valid_out, 1'b0);
      check("rst_instr", instr_out, 32'h0000_0013);
      check("rst_pc_out", pc_out, 32'h0);
      rst_n = 1;

      // Streaming from reset
      t_gnt = -1; t_val = -1;
      for (int i = 0; i < 20 && t_val < 0; i++) begin
         tick();
         if (t_gnt < 0 && imem_req && imem_gnt) t_gnt = i;
         if (instr_valid_out) t_val = i;
      end
      check("first_valid_latency", 32'(t_val - t_gnt), 32'd2);
      collect(4);
      check("seq_pc0", pcs[0], 32'h0000_0000);
      check("seq_pc1", pcs[1], 32'h0000_0004);
      check("seq_pc2", pcs[2], 32'h0000_0008);
      check("seq_pc3", pcs[3], 32'h0000_000C);
      check("seq_ins0", ins[0], 32'h5A5A_0000);
      check("seq_ins3", ins[3], 32'h5A5A_000C);

      // Back-pressure fills the buffer
      stall_in = 1;
      repeat (5) tick();
      check("stall_full_valid", instr_valid_out, 1'b1);
      check("stall_req_low", imem_req, 1'b0);
      check("stall_head_pc", pc_out, 32'h0000_0010);
      check("stall_head_ins", instr_out, 32'h5A5A_0010);
      stall_in = 0;
      collect(3);
      check("post_stall_pc0", pcs[0], 32'h0000_0010);
      check("post_stall_pc1", pcs[1], 32'h0000_0014);
      check("post_stall_pc2", pcs[2], 32'h0000_0018);
      check("post_stall_ins2", ins[2], 32'h5A5A_0018);

      // Grant withheld after a redirect to 0x200
      gnt_en = 0;
      repeat (4) tick();
      redirect_valid = 1; redirect_pc = 32'h0000_0200;
      tick();
      redirect_valid = 0;
      for (int k = 0; k < 3; k++) begin
         check("nognt_req", imem_req, 1'b1);
         check("nognt_addr", imem_addr, 32'h0000_0200);
         check("nognt_valid", instr_valid_out, 1'b0);
         check("nognt_instr", instr_out, 32'h0000_0013);
         tick();
      end
      gnt_en = 1;
      collect(2);
      check("gnt_resume_pc0", pcs[0], 32'h0000_0200);
      check("gnt_resume_pc1", pcs[1], 32'h0000_0204);

      // Redirect while waiting on a response; misaligned target
      rv_delay = 2;
      wait_gnt();
      tick();
      check("wait_rvalid_low", imem_rvalid, 1'b0);
      check("wait_req_low", imem_req, 1'b0);
      redirect_valid = 1; redirect_pc = 32'h0000_0103;
      tick();
      redirect_valid = 0;
      check("drop_req_low", imem_req, 1'b0);
      wait_req();
      check("redir_aligned_addr", imem_addr, 32'h0000_0100);
      rv_delay = 0;
      collect(2);
      check("redir_wait_pc0", pcs[0], 32'h0000_0100);
      check("redir_wait_ins0", ins[0], 32'h5A5A_0100);
      check("redir_wait_pc1", pcs[1], 32'h0000_0104);

      // Redirect in the same cycle as rvalid
      wait_gnt();
      tick();
      check("same_rvalid_seen", imem_rvalid, 1'b1);
      redirect_valid = 1; redirect_pc = 32'h0000_0300;
      tick();
      redirect_valid = 0;
      check("same_rvalid_req", imem_req, 1'b1);
      check("same_rvalid_addr", imem_addr, 32'h0000_0300);
      collect(1);
      check("same_rvalid_pc0", pcs[0], 32'h0000_0300);

      // Redirect in the same cycle as gnt
      wait_gnt();
      redirect_valid = 1; redirect_pc = 32'h0000_0400;
      tick();
      redirect_valid = 0;
      check("same_gnt_req_low", imem_req, 1'b0);
      wait_req();
      check("same_gnt_addr", imem_addr, 32'h0000_0400);
      collect(1);
      check("same_gnt_pc0", pcs[0], 32'h0000_0400);
      check("same_gnt_ins0", ins[0], 32'h5A5A_0400);

      // Asynchronous reset in the middle of a transaction
      rv_delay = 3;
      wait_gnt();
      tick();
      check("pre_rst_wait", imem_req, 1'b0);
      rst_n = 0;
      #1;
      check("arst_req", imem_req, 1'b0);
      check("arst_addr", imem_addr, RESET_PC);
      check("arst_valid", instr_valid_out, 1'b0);
      check("arst_instr", instr_out, 32'h0000_0013);
      check("arst_pc_out", pc_out, 32'h0);
      tick();
      tick();
      rst_n = 1;
      rv_delay = 0;
      collect(2);
      check("restart_pc0", pcs[0], 32'h0000_0000);
      check("restart_ins0", ins[0], 32'h5A5A_0000);
      check("restart_pc1", pcs[1], 32'h0000_0004);

      repeat (3) tick();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, vectors %0d miscompares %0d", vectors, miscompares);
      $fatal(1, "watchdog");
   end

endmodule
